heater_ramp_ctrl: RTL and testbench
===================================

# heater_ramp_ctrl

Parametrised sequencer for the heater array. It replaces the direct, all-at-once drive of the heater enable bits with a controlled ramp: channels turn on one at a time and turn off one at a time, which bounds di/dt on the FPGA supply rails. It latches and counts heater errors, and can optionally trip a faulted channel off until software clears it. It runs in the heater clock domain, between the debug/VIO control registers and the `heater` instances.

## Interface
Parameters:
- `N`, 32: number of heater channels.
- `RAMP_DIV`, 1024: clock cycles between successive enable or disable steps; must be ≥ 2.
- `CW`, 16: width of the saturating error-event counter.

Ports:
- `clk`, input, 1: heater clock. All I/O is synchronous to `clk`.
- `reset`, input, 1: synchronous, active-high reset.
- `target_mask`, input, N: channels to enable. Latched on an accepted `start`.
- `start`, input, 1: pulse. Begins the ramp-up. Accepted only in IDLE.
- `stop`, input, 1: pulse. Begins the ramp-down. Accepted only in RAMP_UP or HOLD.
- `trip_en`, input, 1: when 1, an error disables its channel; when 0, errors are logged only.
- `clear_errors`, input, 1: pulse. Clears latched errors, trips and the counter.
- `err_in`, input, N: per-heater error level. Sticky until that heater sees `err_clear`.
- `heater_enable`, output, N: registered enable bit to each heater.
- `err_clear`, output, N: registered one-cycle clear pulse to each heater.
- `err_sticky`, output, N: latched per-channel error flags.
- `err_total`, output, CW: count of error rising edges, saturating.
- `active_count`, output, $clog2(N+1): popcount of `heater_enable`.
- `state`, output, 2: IDLE=0, RAMP_UP=1, HOLD=2, RAMP_DOWN=3.
- `busy`, output, 1: high whenever `state` is not IDLE.

## Operation
- Reset value of every output and internal register is 0. `state` resets to IDLE.
- Internal registers: `tgt` (latched target), `tripped[N]`, `err_q` (`err_in` delayed one cycle), step timer `tmr` (0..RAMP_DIV-1).
- Eligible set: `elig = tgt & ~heater_enable & ~tripped`.
- IDLE:
  - On `start`: `tgt <= target_mask`, `tmr <= 0`, go to RAMP_UP.
  - `stop` is ignored.
- RAMP_UP:
  - `tmr` increments every cycle.
  - When `tmr == RAMP_DIV-1`: set the lowest-index bit of `elig` in `heater_enable`, and reset `tmr` to 0.
  - When `elig == 0` (checked every cycle): go to HOLD.
  - On `stop`: `tmr <= 0`, go to RAMP_DOWN. `stop` has priority over the HOLD transition.
- HOLD:
  - Enables are static except for trips.
  - On `stop`: go to RAMP_DOWN.
  - On `clear_errors` while `tgt & tripped != 0`: `tmr <= 0`, go to RAMP_UP so the cleared channels ramp back in.
- RAMP_DOWN:
  - When `tmr == RAMP_DIV-1`: clear the highest-index set bit of `heater_enable`.
  - When `heater_enable == 0`: go to IDLE.
  - `start` and `stop` are ignored.
- Error detection: `edge = err_in & ~err_q`. An `err_in` bit already high when reset is released counts as an edge.
- Per edge bit i:
  - `err_sticky[i] <= 1`.
  - If `trip_en`: `tripped[i] <= 1` and `heater_enable[i] <= 0`. A trip overrides a ramp step to the same bit in the same cycle.
  - `err_total <= min(err_total + popcount(edge), 2^CW-1)`.
- `clear_errors`:
  - `err_clear <= err_sticky` for exactly one cycle.
  - `err_sticky`, `tripped` and `err_total` go to 0.
  - A same-cycle edge wins for its channel: that bit stays set and `err_total <= popcount(edge)`.
- `clear_errors` is accepted in any state. A simultaneous `stop` takes state priority, but the clear is still performed.
- Tripped channels are skipped by the ramp-up and stay off until cleared.
- `reset` asserted mid-operation: all enables drop to 0 at the next edge, with no ramp-down.

## Timing
- Let `start` be sampled at edge t:
  - `state` = RAMP_UP from t+1.
  - Steps land at t+RAMP_DIV, t+2·RAMP_DIV, …
  - HOLD is entered one edge after the final step.
- `start` with `target_mask == 0`: RAMP_UP at t+1, HOLD at t+2.
- `stop` sampled at edge t: RAMP_DOWN at t+1; the first disable lands at t+RAMP_DIV.
- Error response: `err_in` rising before edge t produces `err_sticky`, trip and `err_total` updates at edge t (1-cycle latency).
- `active_count` lags `heater_enable` by one cycle.
- `err_clear` pulses at the edge after `clear_errors` is sampled.

## Test plan
- Ramp-up, N=4, RAMP_DIV=4, target=1011, start sampled at edge t:
  - `heater_enable` = 0001@t+4, 0011@t+8, 1011@t+12.
  - `state` = HOLD@t+13; `active_count` = 3@t+13.
- Ramp-down: stop sampled at edge t in HOLD with enables 1011:
  - `heater_enable` = 0011@t+4, 0001@t+8, 0000@t+12.
  - `state` = IDLE@t+13; `busy` = 0.
- Trip then recover:
  - `trip_en`=1, HOLD with 1011, `err_in[1]` rises before edge t: `heater_enable` = 1001, `err_sticky` = 0010, `err_total` = 1 @t.
  - `clear_errors` sampled at t2: `err_clear` = 0010 for one cycle at t2; `err_sticky`, `err_total` = 0; `state` = RAMP_UP.
  - `heater_enable` returns to 1011 at t2+4.
- Log-only mode: `trip_en`=0, `err_in[0]` and `err_in[3]` rise in the same cycle:
  - `err_total` goes from 0 to 2; enables unchanged.
  - With CW=2, 5 single events leave `err_total` = 3.
- Trip during ramp-up: channel 0 errors before its step:
  - Channel 0 is skipped; the enable order is 0010, then 1010.
  - HOLD is entered with `tripped` = 0001.
- Reset mid-RAMP_UP with enables 0011:
  - At the next edge, all outputs are 0 and `state` = IDLE.
  - A subsequent `start` ramps from zero.

Source files
------------

// File: rtl/heater_ramp_ctrl.sv
// Purpose : sequences heater enables on one channel at a time (up: lowest index first, down: highest first)
//           and latches/counts heater errors, with optional per-channel trip until software clears it.
// Latency : one step every RAMP_DIV cycles; error edges land in err_sticky/err_total/trips one cycle after err_in rises.
// Backpressure: none; start/stop/clear_errors are single-cycle pulses, ignored in states that do not accept them.
//
// Ports:
//   clk, reset (sync, active-high)       - heater clock domain
//   target_mask, start, stop             - ramp control from the VIO/debug registers
//   trip_en, clear_errors, err_in        - error policy, clear pulse, per-heater error levels
//   heater_enable, err_clear             - registered drives to the heater instances
//   err_sticky, err_total, active_count  - status
//   state, busy                          - IDLE=0, RAMP_UP=1, HOLD=2, RAMP_DOWN=3; busy when not IDLE
module heater_ramp_ctrl #(
  parameter int N        = 32,
  parameter int RAMP_DIV = 1024,
  parameter int CW       = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [N-1:0]           target_mask,
  input  logic                   start,
  input  logic                   stop,
  input  logic                   trip_en,
  input  logic                   clear_errors,
  input  logic [N-1:0]           err_in,
  output logic [N-1:0]           heater_enable,
  output logic [N-1:0]           err_clear,
  output logic [N-1:0]           err_sticky,
  output logic [CW-1:0]          err_total,
  output logic [$clog2(N+1)-1:0] active_count,
  output logic [1:0]             state,
  output logic                   busy
);

  localparam int AW = $clog2(N+1);
  localparam int TW = $clog2(RAMP_DIV);
  // Sum width wide enough that err_total + popcount(edge) never wraps before saturation.
  localparam int SW = ((CW > AW) ? CW : AW) + 1;

  localparam logic [TW-1:0] TMR_LAST = TW'(RAMP_DIV - 1);
  localparam logic [SW-1:0] TOT_MAX  = {{(SW-CW){1'b0}}, {CW{1'b1}}};

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    RAMP_UP   = 2'd1,
    HOLD      = 2'd2,
    RAMP_DOWN = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [N-1:0]    tgt_q, tgt_d;
  logic [N-1:0]    tripped_q, tripped_d;
  logic [N-1:0]    err_dly_q, err_dly_d;
  logic [TW-1:0]   tmr_q, tmr_d;
  logic [N-1:0]    heater_enable_q, heater_enable_d;
  logic [N-1:0]    err_clear_q, err_clear_d;
  logic [N-1:0]    err_sticky_q, err_sticky_d;
  logic [CW-1:0]   err_total_q, err_total_d;
  logic [AW-1:0]   active_count_q, active_count_d;

  logic [N-1:0]    err_edge;
  logic [N-1:0]    elig;
  logic [N-1:0]    lo_bit;
  logic [N-1:0]    hi_bit;
  logic            step_now;
  logic [AW-1:0]   edge_cnt;
  logic [SW-1:0]   tot_sum;

  function automatic logic [AW-1:0] popcnt(input logic [N-1:0] v);
    logic [AW-1:0] c;
    c = '0;
    for (int i = 0; i < N; i++) begin
      c = c + AW'(v[i]);
    end
    return c;
  endfunction

  always_comb begin
    err_edge = err_in & ~err_dly_q;
    elig     = tgt_q & ~heater_enable_q & ~tripped_q;
    step_now = (tmr_q == TMR_LAST);
    // Two's-complement trick isolates the lowest set bit of elig.
    lo_bit   = elig & (~elig + N'(1));
    // Scan upward so the last hit is the highest enabled channel.
    hi_bit   = '0;
    for (int i = 0; i < N; i++) begin
      if (heater_enable_q[i]) begin
        hi_bit    = '0;
        hi_bit[i] = 1'b1;
      end
    end
    edge_cnt = popcnt(err_edge);

    state_d         = state_q;
    tgt_d           = tgt_q;
    tripped_d       = tripped_q;
    err_dly_d       = err_in;
    tmr_d           = tmr_q;
    heater_enable_d = heater_enable_q;
    err_clear_d     = '0;
    err_sticky_d    = err_sticky_q;
    err_total_d     = err_total_q;
    active_count_d  = popcnt(heater_enable_q);
    tot_sum         = '0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          tgt_d   = target_mask;
          tmr_d   = '0;
          state_d = RAMP_UP;
        end
      end
      RAMP_UP: begin
        if (step_now) begin
          heater_enable_d = heater_enable_q | lo_bit;
          tmr_d           = '0;
        end else begin
          tmr_d = tmr_q + TW'(1);
        end
        if (stop) begin
          tmr_d   = '0;
          state_d = RAMP_DOWN;
        end else if (elig == '0) begin
          state_d = HOLD;
        end
      end
      HOLD: begin
        // Timer restarts so the first disable is a full RAMP_DIV after stop.
        if (stop) begin
          tmr_d   = '0;
          state_d = RAMP_DOWN;
        end else if (clear_errors && ((tgt_q & tripped_q) != '0)) begin
          tmr_d   = '0;
          state_d = RAMP_UP;
        end
      end
      RAMP_DOWN: begin
        if (step_now) begin
          heater_enable_d = heater_enable_q & ~hi_bit;
          tmr_d           = '0;
        end else begin
          tmr_d = tmr_q + TW'(1);
        end
        if (heater_enable_q == '0) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Error handling comes after the FSM so a trip overrides a same-cycle ramp step.
    if (clear_errors) begin
      err_clear_d  = err_sticky_q;
      err_sticky_d = err_edge;
      tripped_d    = trip_en ? err_edge : '0;
      tot_sum      = SW'(edge_cnt);
    end else begin
      err_sticky_d = err_sticky_q | err_edge;
      if (trip_en) begin
        tripped_d = tripped_q | err_edge;
      end
      tot_sum = SW'(err_total_q) + SW'(edge_cnt);
    end
    err_total_d = (tot_sum > TOT_MAX) ? err_total_q | {CW{1'b1}} : tot_sum[CW-1:0];

    if (trip_en) begin
      heater_enable_d = heater_enable_d & ~err_edge;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= IDLE;
      tgt_q           <= '0;
      tripped_q       <= '0;
      err_dly_q       <= '0;
      tmr_q           <= '0;
      heater_enable_q <= '0;
      err_clear_q     <= '0;
      err_sticky_q    <= '0;
      err_total_q     <= '0;
      active_count_q  <= '0;
    end else begin
      state_q         <= state_d;
      tgt_q           <= tgt_d;
      tripped_q       <= tripped_d;
      err_dly_q       <= err_dly_d;
      tmr_q           <= tmr_d;
      heater_enable_q <= heater_enable_d;
      err_clear_q     <= err_clear_d;
      err_sticky_q    <= err_sticky_d;
      err_total_q     <= err_total_d;
      active_count_q  <= active_count_d;
    end
  end

  assign heater_enable = heater_enable_q;
  assign err_clear     = err_clear_q;
  assign err_sticky    = err_sticky_q;
  assign err_total     = err_total_q;
  assign active_count  = active_count_q;
  assign state         = state_q;
  assign busy          = (state_q != IDLE);

endmodule

// File: tb/tb_heater_ramp_ctrl.sv
module tb_heater_ramp_ctrl;
  localparam int N  = 4;
  localparam int RD = 4;
  localparam int AW = $clog2(N+1);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_UP   = 2'd1;
  localparam logic [1:0] S_HOLD = 2'd2;
  localparam logic [1:0] S_DOWN = 2'd3;

  logic          clk = 1'b0;
  logic          reset;
  logic [N-1:0]  target_mask;
  logic          start, stop, trip_en, clear_errors;
  logic [N-1:0]  err_in;
  logic [N-1:0]  heater_enable, err_clear, err_sticky;
  logic [15:0]   err_total;
  logic [AW-1:0] active_count;
  logic [1:0]    state;
  logic          busy;
  logic [N-1:0]  s_heater_enable, s_err_clear, s_err_sticky;
  logic [1:0]    s_err_total;
  logic [AW-1:0] s_active_count;
  logic [1:0]    s_state;
  logic          s_busy;

  int checks = 0;
  int errors = 0;
  int cyc_cnt = 0;
  logic [N-1:0] prev_en;

  typedef struct {
    int           cyc;
    logic [N-1:0] en;
  } ev_t;
  ev_t sb_q[$];

  always #5 clk = ~clk;

  heater_ramp_ctrl #(.N(N), .RAMP_DIV(RD), .CW(16)) dut (
    .clk(clk), .reset(reset), .target_mask(target_mask), .start(start), .stop(stop),
    .trip_en(trip_en), .clear_errors(clear_errors), .err_in(err_in),
    .heater_enable(heater_enable), .err_clear(err_clear), .err_sticky(err_sticky),
    .err_total(err_total), .active_count(active_count), .state(state), .busy(busy)
  );

  // Narrow-counter instance sharing the same stimulus, used for saturation.
  heater_ramp_ctrl #(.N(N), .RAMP_DIV(RD), .CW(2)) dut_sat (
    .clk(clk), .reset(reset), .target_mask(target_mask), .start(start), .stop(stop),
    .trip_en(trip_en), .clear_errors(clear_errors), .err_in(err_in),
    .heater_enable(s_heater_enable), .err_clear(s_err_clear), .err_sticky(s_err_sticky),
    .err_total(s_err_total), .active_count(s_active_count), .state(s_state), .busy(s_busy)
  );

  task automatic tick();
    @(posedge clk);
    #1;
    cyc_cnt++;
  endtask

  task automatic sb_push(input int c, input logic [N-1:0] e);
    ev_t ev;
    ev.cyc = c;
    ev.en  = e;
    sb_q.push_back(ev);
  endtask

  // Pop one expected enable event each time heater_enable changes.
  task automatic drain_sb(input int budget);
    ev_t e;
    int  n;
    n = 0;
    while (sb_q.size() > 0 && n < budget) begin
      tick();
      n++;
      if (heater_enable !== prev_en) begin
        e = sb_q.pop_front();
        checks++;
        if (heater_enable !== e.en || cyc_cnt != e.cyc) begin
          errors++;
          $display("FAIL sb_enable: got %b at t+%0d, want %b at t+%0d", heater_enable, cyc_cnt, e.en, e.cyc);
        end
        prev_en = heater_enable;
      end
    end
    if (sb_q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL sb_timeout: %0d enable events missing, enable=%b", sb_q.size(), heater_enable);
      sb_q.delete();
    end
  endtask

  task automatic wait_state(input logic [1:0] s, input int budget, input string name);
    int n;
    n = 0;
    while (state !== s && n < budget) begin
      tick();
      n++;
    end
    checks++;
    if (state !== s) begin
      errors++;
      $display("FAIL %s: state=%0d want %0d after %0d cycles", name, state, s, n);
    end
  endtask

  task automatic start_ramp(input logic [N-1:0] mask);
    prev_en     = heater_enable;
    target_mask = mask;
    start       = 1'b1;
    tick();
    start       = 1'b0;
    cyc_cnt     = 0;
  endtask

  task automatic reset_pulse();
    err_in = '0; trip_en = 1'b0; reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; err_in = 4'b0001;
    tick(); tick();
    checks++;
    if ({heater_enable, err_clear, err_sticky} !== 12'h000) begin
      errors++; $display("FAIL reset_vectors: en/clr/sticky=%h want 000", {heater_enable, err_clear, err_sticky});
    end
    checks++;
    if (err_total !== 16'd0 || active_count !== '0) begin
      errors++; $display("FAIL reset_counts: total=%0d active=%0d want 0 0", err_total, active_count);
    end
    checks++;
    if (state !== S_IDLE || busy !== 1'b0) begin
      errors++; $display("FAIL reset_state: state=%0d busy=%b want 0 0", state, busy);
    end
    reset = 1'b0;
    tick();
    checks++;
    if (err_sticky !== 4'b0001 || err_total !== 16'd1) begin
      errors++; $display("FAIL err_at_release: sticky=%b total=%0d want 0001 1", err_sticky, err_total);
    end
    err_in = '0; clear_errors = 1'b1;
    tick();
    clear_errors = 1'b0;
    checks++;
    if (err_clear !== 4'b0001 || err_sticky !== 4'b0000 || err_total !== 16'd0) begin
      errors++; $display("FAIL clear_idle: clr=%b sticky=%b total=%0d want 0001 0000 0", err_clear, err_sticky, err_total);
    end
    tick();
    checks++;
    if (err_clear !== 4'b0000) begin
      errors++; $display("FAIL clear_one_cycle: clr=%b want 0000", err_clear);
    end
  endtask

  task automatic test_ramp_up();
    start_ramp(4'b1011);
    sb_push(4, 4'b0001); sb_push(8, 4'b0011); sb_push(12, 4'b1011);
    tick();
    checks++;
    if (state !== S_UP || busy !== 1'b1) begin
      errors++; $display("FAIL up_enter: state=%0d busy=%b want 1 1", state, busy);
    end
    drain_sb(20);
    checks++;
    if (active_count !== 3'd2) begin
      errors++; $display("FAIL up_active_lag: active=%0d want 2", active_count);
    end
    tick();
    checks++;
    if (state !== S_HOLD || active_count !== 3'd3) begin
      errors++; $display("FAIL up_hold: state=%0d active=%0d want 2 3 at t+%0d", state, active_count, cyc_cnt);
    end
  endtask

  task automatic test_ramp_down();
    prev_en = heater_enable;
    stop = 1'b1;
    tick();
    stop = 1'b0; cyc_cnt = 0;
    sb_push(4, 4'b0011); sb_push(8, 4'b0001); sb_push(12, 4'b0000);
    tick();
    checks++;
    if (state !== S_DOWN) begin
      errors++; $display("FAIL down_enter: state=%0d want 3", state);
    end
    drain_sb(20);
    tick();
    checks++;
    if (state !== S_IDLE || busy !== 1'b0 || active_count !== 3'd0) begin
      errors++; $display("FAIL down_idle: state=%0d busy=%b active=%0d want 0 0 0", state, busy, active_count);
    end
    stop = 1'b1;
    tick();
    stop = 1'b0;
    checks++;
    if (state !== S_IDLE) begin
      errors++; $display("FAIL stop_in_idle: state=%0d want 0", state);
    end
  endtask

  task automatic test_trip_recover();
    start_ramp(4'b1011);
    wait_state(S_HOLD, 40, "recover_hold");
    trip_en = 1'b1; err_in = 4'b0010;
    tick();
    checks++;
    if (heater_enable !== 4'b1001 || err_sticky !== 4'b0010 || err_total !== 16'd1) begin
      errors++; $display("FAIL trip: en=%b sticky=%b total=%0d want 1001 0010 1", heater_enable, err_sticky, err_total);
    end
    clear_errors = 1'b1;
    tick();
    clear_errors = 1'b0; err_in = '0; cyc_cnt = 0; prev_en = heater_enable;
    checks++;
    if (err_clear !== 4'b0010 || err_sticky !== 4'b0000 || err_total !== 16'd0 || state !== S_UP) begin
      errors++; $display("FAIL recover_clear: clr=%b sticky=%b total=%0d state=%0d want 0010 0000 0 1",
                         err_clear, err_sticky, err_total, state);
    end
    sb_push(4, 4'b1011);
    tick();
    checks++;
    if (err_clear !== 4'b0000) begin
      errors++; $display("FAIL recover_clr_pulse: clr=%b want 0000", err_clear);
    end
    drain_sb(20);
    tick();
    checks++;
    if (state !== S_HOLD) begin
      errors++; $display("FAIL recover_hold_again: state=%0d want 2", state);
    end
  endtask

  task automatic test_log_only();
    trip_en = 1'b0; err_in = 4'b1001;
    tick();
    checks++;
    if (err_total !== 16'd2 || s_err_total !== 2'd2 || heater_enable !== 4'b1011 || err_sticky !== 4'b1001) begin
      errors++; $display("FAIL log_dual: total=%0d sat=%0d en=%b sticky=%b want 2 2 1011 1001",
                         err_total, s_err_total, heater_enable, err_sticky);
    end
    err_in = '0;
    tick();
    for (int k = 0; k < 5; k++) begin
      err_in = 4'b0100; tick();
      err_in = 4'b0000; tick();
    end
    checks++;
    if (err_total !== 16'd7 || s_err_total !== 2'd3 || heater_enable !== 4'b1011) begin
      errors++; $display("FAIL log_saturate: total=%0d sat=%0d en=%b want 7 3 1011", err_total, s_err_total, heater_enable);
    end
    clear_errors = 1'b1;
    tick();
    checks++;
    if (err_clear !== 4'b1101 || err_total !== 16'd0 || state !== S_HOLD) begin
      errors++; $display("FAIL log_clear: clr=%b total=%0d state=%0d want 1101 0 2", err_clear, err_total, state);
    end
    err_in = 4'b0001;
    tick();
    checks++;
    if (err_sticky !== 4'b0001 || err_total !== 16'd1 || err_clear !== 4'b0000) begin
      errors++; $display("FAIL clear_vs_edge: sticky=%b total=%0d clr=%b want 0001 1 0000", err_sticky, err_total, err_clear);
    end
    err_in = '0;
    tick();
    clear_errors = 1'b0;
    checks++;
    if (err_clear !== 4'b0001 || err_sticky !== 4'b0000) begin
      errors++; $display("FAIL clear_after_edge: clr=%b sticky=%b want 0001 0000", err_clear, err_sticky);
    end
    stop = 1'b1;
    tick();
    stop = 1'b0;
    wait_state(S_IDLE, 40, "log_ramp_down");
  endtask

  task automatic test_trip_during_ramp();
    trip_en = 1'b1;
    start_ramp(4'b1011);
    err_in = 4'b0001;
    sb_push(4, 4'b0010); sb_push(8, 4'b1010);
    drain_sb(20);
    tick();
    checks++;
    if (state !== S_HOLD || dut.tripped_q !== 4'b0001 || err_sticky !== 4'b0001) begin
      errors++; $display("FAIL trip_ramp_hold: state=%0d tripped=%b sticky=%b want 2 0001 0001",
                         state, dut.tripped_q, err_sticky);
    end
    reset_pulse();
  endtask

  task automatic test_reset_mid_ramp();
    start_ramp(4'b1011);
    sb_push(4, 4'b0001); sb_push(8, 4'b0011);
    drain_sb(20);
    checks++;
    if (heater_enable !== 4'b0011 || state !== S_UP) begin
      errors++; $display("FAIL pre_reset: en=%b state=%0d want 0011 1", heater_enable, state);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++;
    if (heater_enable !== 4'b0000 || active_count !== '0 || state !== S_IDLE || busy !== 1'b0) begin
      errors++; $display("FAIL mid_reset: en=%b active=%0d state=%0d busy=%b want 0000 0 0 0",
                         heater_enable, active_count, state, busy);
    end
    start_ramp(4'b0011);
    sb_push(4, 4'b0001); sb_push(8, 4'b0011);
    drain_sb(20);
    tick();
    checks++;
    if (state !== S_HOLD || active_count !== 3'd2) begin
      errors++; $display("FAIL restart_hold: state=%0d active=%0d want 2 2", state, active_count);
    end
    reset_pulse();
  endtask

  task automatic test_zero_target();
    start_ramp(4'b0000);
    tick(); tick();
    checks++;
    if (state !== S_HOLD || heater_enable !== 4'b0000 || busy !== 1'b1) begin
      errors++; $display("FAIL zero_target: state=%0d en=%b busy=%b want 2 0000 1", state, heater_enable, busy);
    end
    stop = 1'b1;
    tick();
    stop = 1'b0;
    wait_state(S_IDLE, 10, "zero_stop");
  endtask

  task automatic test_stop_in_ramp_up();
    start_ramp(4'b1111);
    sb_push(4, 4'b0001);
    drain_sb(20);
    tick();
    prev_en = heater_enable;
    stop = 1'b1;
    tick();
    stop = 1'b0; cyc_cnt = 0;
    sb_push(4, 4'b0000);
    tick();
    checks++;
    if (state !== S_DOWN) begin
      errors++; $display("FAIL stop_up_enter: state=%0d want 3", state);
    end
    drain_sb(20);
    tick();
    checks++;
    if (state !== S_IDLE) begin
      errors++; $display("FAIL stop_up_idle: state=%0d want 0 at t+%0d", state, cyc_cnt);
    end
  endtask

  initial begin
    reset = 1'b1; target_mask = '0; start = 1'b0; stop = 1'b0;
    trip_en = 1'b0; clear_errors = 1'b0; err_in = '0; prev_en = '0;
    test_reset();
    test_ramp_up();
    test_ramp_down();
    test_trip_recover();
    test_log_only();
    test_trip_during_ramp();
    test_reset_mid_ramp();
    test_zero_target();
    test_stop_in_ramp_up();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule
